// File: rtl/reorder_buffer_pkg.sv
// Shared definitions for the reorder buffer and the blocks that exchange
// ROB tags with it (register status table, reservation stations).
//   TAG_W : ROB tag width; tag 0 means "no producer"
//   DEPTH : number of entries, always 2^TAG_W-1 (tags 1..DEPTH)
//   XLEN  : data width
//   rob_entry_t : per-entry state held by the reorder buffer
package reorder_buffer_pkg;

  localparam int unsigned TAG_W = 4;
  localparam int unsigned DEPTH = 15;
  localparam int unsigned XLEN  = 32;

  typedef struct packed {
    logic            valid;
    logic            ready;
    logic [4:0]      dest;
    logic            writes;
    logic            is_store;
    logic            mispredict;
    logic [XLEN-1:0] value;
  } rob_entry_t;

endpackage

// File: rtl/reorder_buffer_rob_ptr.sv
// Wrap-around ROB pointer covering 1..PTR_MAX; 0 is never produced.
//   clk, reset : clock, synchronous active-high reset (pointer -> 1)
//   inc        : advance by one, wrapping PTR_MAX -> 1
//   clear      : return to 1 (takes priority over inc)
//   ptr        : current pointer value
module rob_ptr
  import reorder_buffer_pkg::*;
#(
  parameter int unsigned PTR_W   = TAG_W,
  parameter int unsigned PTR_MAX = DEPTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clear,
  output logic [PTR_W-1:0] ptr
);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      ptr <= PTR_W'(1);
    end else if (inc) begin
      ptr <= (ptr == PTR_W'(PTR_MAX)) ? PTR_W'(1) : ptr + PTR_W'(1);
    end
  end

endmodule

// File: rtl/reorder_buffer.sv
// Circular reorder buffer between issue and commit.
//   issue_*  : allocate the tail entry; issue_ROB is the tag handed out
//   cdb_*    : completion broadcast, marks an entry ready with its result
//   rd_*     : operand lookup by tag, with same-cycle CDB forwarding
//   commit_*, RegWrite, mem_write : in-order retirement of the head entry
//   flush    : head retires a mispredicted branch; all state clears next edge
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             issue_valid,
  input  logic [4:0]       issue_dest,
  input  logic             issue_writes,
  input  logic             issue_is_store,
  output logic             issue_ready,
  output logic [TAG_W-1:0] issue_ROB,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_ROB,
  input  logic [XLEN-1:0]  cdb_value,
  input  logic             cdb_mispredict,
  input  logic [TAG_W-1:0] rd_tag_j,
  input  logic [TAG_W-1:0] rd_tag_k,
  output logic             rd_ready_j,
  output logic             rd_ready_k,
  output logic [XLEN-1:0]  rd_value_j,
  output logic [XLEN-1:0]  rd_value_k,
  output logic             commit_valid,
  output logic [TAG_W-1:0] commit_ROB,
  output logic [4:0]       commit_dest,
  output logic [XLEN-1:0]  commit_value,
  output logic             RegWrite,
  output logic             mem_write,
  output logic             flush
);

  localparam logic [TAG_W-1:0] FULL = TAG_W'(DEPTH);

  // Index 0 exists only so a TAG_W-bit tag indexes directly; it is never
  // allocated and therefore never valid.
  rob_entry_t       rob [DEPTH+1];
  rob_entry_t       head_e;
  logic [TAG_W-1:0] head;
  logic [TAG_W-1:0] tail;
  logic [TAG_W-1:0] count;
  logic             alloc;
  logic             cdb_wr;

  assign head_e       = rob[head];
  assign commit_valid = head_e.valid & head_e.ready;
  assign flush        = commit_valid & head_e.mispredict;
  assign issue_ready  = (count < FULL) & ~flush;
  assign issue_ROB    = tail;
  assign alloc        = issue_valid & issue_ready;
  assign cdb_wr       = cdb_valid & (cdb_ROB != '0) & rob[cdb_ROB].valid;

  assign commit_ROB   = commit_valid ? head : '0;
  assign commit_dest  = commit_valid ? head_e.dest : '0;
  assign commit_value = commit_valid ? head_e.value : '0;
  assign RegWrite     = commit_valid & head_e.writes & (head_e.dest != '0);
  assign mem_write    = commit_valid & head_e.is_store;

  // Returns {ready, value}. A live CDB broadcast to the tag wins over the
  // stored value so a dependent can issue in the completion cycle.
  function automatic logic [XLEN:0] operand(input rob_entry_t e,
                                            input logic [TAG_W-1:0] tag,
                                            input logic hit,
                                            input logic [XLEN-1:0] cval);
    if (tag == '0 || !e.valid) return '0;
    if (hit) return {1'b1, cval};
    if (e.ready) return {1'b1, e.value};
    return '0;
  endfunction

  assign {rd_ready_j, rd_value_j} =
    operand(rob[rd_tag_j], rd_tag_j, cdb_valid && (cdb_ROB == rd_tag_j), cdb_value);
  assign {rd_ready_k, rd_value_k} =
    operand(rob[rd_tag_k], rd_tag_k, cdb_valid && (cdb_ROB == rd_tag_k), cdb_value);

  rob_ptr #(.PTR_W(TAG_W), .PTR_MAX(DEPTH)) u_head (
    .clk   (clk),
    .reset (reset),
    .inc   (commit_valid),
    .clear (flush),
    .ptr   (head)
  );

  rob_ptr #(.PTR_W(TAG_W), .PTR_MAX(DEPTH)) u_tail (
    .clk   (clk),
    .reset (reset),
    .inc   (alloc),
    .clear (flush),
    .ptr   (tail)
  );

  // Head and tail coincide only when empty (head invalid, so no commit or
  // CDB write there) or full (no allocation), so the three writes below
  // never collide on the same field.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      for (int unsigned i = 0; i <= DEPTH; i++) rob[i] <= '0;
      count <= '0;
    end else begin
      if (cdb_wr) begin
        rob[cdb_ROB].ready      <= 1'b1;
        rob[cdb_ROB].value      <= cdb_value;
        rob[cdb_ROB].mispredict <= cdb_mispredict;
      end
      if (commit_valid) rob[head].valid <= 1'b0;
      if (alloc) begin
        rob[tail] <= '{valid: 1'b1, ready: 1'b0, dest: issue_dest,
                       writes: issue_writes, is_store: issue_is_store,
                       mispredict: 1'b0, value: '0};
      end
      case ({alloc, commit_valid})
        2'b10:   count <= count + TAG_W'(1);
        2'b01:   count <= count - TAG_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
module tb_reorder_buffer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        issue_valid = 1'b0;
  logic [4:0]  issue_dest = '0;
  logic        issue_writes = 1'b0;
  logic        issue_is_store = 1'b0;
  logic        issue_ready;
  logic [3:0]  issue_ROB;
  logic        cdb_valid = 1'b0;
  logic [3:0]  cdb_ROB = '0;
  logic [31:0] cdb_value = '0;
  logic        cdb_mispredict = 1'b0;
  logic [3:0]  rd_tag_j = '0;
  logic [3:0]  rd_tag_k = '0;
  logic        rd_ready_j, rd_ready_k;
  logic [31:0] rd_value_j, rd_value_k;
  logic        commit_valid;
  logic [3:0]  commit_ROB;
  logic [4:0]  commit_dest;
  logic [31:0] commit_value;
  logic        RegWrite, mem_write, flush;

  reorder_buffer dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_dest(issue_dest),
    .issue_writes(issue_writes), .issue_is_store(issue_is_store),
    .issue_ready(issue_ready), .issue_ROB(issue_ROB),
    .cdb_valid(cdb_valid), .cdb_ROB(cdb_ROB), .cdb_value(cdb_value),
    .cdb_mispredict(cdb_mispredict),
    .rd_tag_j(rd_tag_j), .rd_tag_k(rd_tag_k),
    .rd_ready_j(rd_ready_j), .rd_ready_k(rd_ready_k),
    .rd_value_j(rd_value_j), .rd_value_k(rd_value_k),
    .commit_valid(commit_valid), .commit_ROB(commit_ROB),
    .commit_dest(commit_dest), .commit_value(commit_value),
    .RegWrite(RegWrite), .mem_write(mem_write), .flush(flush)
  );

  always #5 clk = ~clk;

  // Reference model: program-order list of in-flight instructions.
  typedef struct {
    int          tag;
    logic [4:0]  dest;
    bit          wr, st, done, misp;
    logic [31:0] val;
  } ment_t;

  typedef struct {
    int          tag;
    logic [4:0]  dest;
    logic [31:0] val;
    bit          rw, mw, fl;
  } exp_t;

  ment_t q[$];
  exp_t  sb[$];
  int    next_tag = 1;
  int    total = 0;
  int    bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
    end
  endtask

  function automatic void lookup(input int tag, input bit cv, input int ct,
                                 input logic [31:0] cval, output bit found,
                                 output bit rdy, output logic [31:0] val);
    found = 0; rdy = 0; val = '0;
    if (tag == 0) return;
    foreach (q[i]) begin
      if (q[i].tag == tag) begin
        found = 1;
        if (cv && ct == tag) begin rdy = 1; val = cval; end
        else if (q[i].done) begin rdy = 1; val = q[i].val; end
      end
    end
  endfunction

  // Monitor: retirements are checked against the scoreboard as they appear.
  always @(negedge clk) begin
    if (!reset) begin
      if (commit_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_commit", {28'd0, commit_ROB}, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("commit_ROB", {28'd0, commit_ROB}, e.tag);
          chk("commit_dest", {27'd0, commit_dest}, {27'd0, e.dest});
          chk("commit_value", commit_value, e.val);
          chk("RegWrite", {31'd0, RegWrite}, {31'd0, e.rw});
          chk("mem_write", {31'd0, mem_write}, {31'd0, e.mw});
          chk("flush", {31'd0, flush}, {31'd0, e.fl});
        end
      end else begin
        chk("missed_commit", sb.size(), 0);
        chk("idle_commit_outs",
            {16'd0, commit_ROB, commit_dest, RegWrite, mem_write, flush, commit_value[3:0]},
            32'd0);
      end
    end
  end

  // One clock cycle: drive inputs, predict, check, then advance the model.
  task automatic step(input bit iv, input logic [4:0] d, input bit w, input bit s,
                      input bit cv, input int ct, input logic [31:0] cval,
                      input bit cm, input int tj, input int tk);
    bit e_commit, e_flush, e_ready, fj, fk, rj, rk;
    logic [31:0] vj, vk;
    issue_valid = iv; issue_dest = d; issue_writes = w; issue_is_store = s;
    cdb_valid = cv; cdb_ROB = 4'(ct); cdb_value = cval; cdb_mispredict = cm;
    rd_tag_j = 4'(tj); rd_tag_k = 4'(tk);
    e_commit = (q.size() > 0) && q[0].done;
    e_flush  = e_commit && q[0].misp;
    e_ready  = (q.size() < 15) && !e_flush;
    if (e_commit)
      sb.push_back('{q[0].tag, q[0].dest, q[0].val, q[0].wr && (q[0].dest != 0), q[0].st, e_flush});
    lookup(tj, cv, ct, cval, fj, rj, vj);
    lookup(tk, cv, ct, cval, fk, rk, vk);
    @(negedge clk);
    chk("issue_ready", {31'd0, issue_ready}, {31'd0, e_ready});
    chk("issue_ROB", {28'd0, issue_ROB}, next_tag);
    chk("rd_ready_j", {31'd0, rd_ready_j}, {31'd0, rj});
    chk("rd_ready_k", {31'd0, rd_ready_k}, {31'd0, rk});
    if (rj || !fj) chk("rd_value_j", rd_value_j, vj);
    if (rk || !fk) chk("rd_value_k", rd_value_k, vk);
    @(posedge clk);
    if (e_flush) begin
      q.delete();
      next_tag = 1;
    end else begin
      if (cv && ct != 0)
        foreach (q[i]) if (q[i].tag == ct) begin
          q[i].done = 1; q[i].val = cval; q[i].misp = cm;
        end
      if (e_commit) void'(q.pop_front());
      if (iv && e_ready) begin
        q.push_back('{next_tag, d, w, s, 1'b0, 1'b0, 32'd0});
        next_tag = (next_tag == 15) ? 1 : next_tag + 1;
      end
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    issue_valid = 0; cdb_valid = 0;
    cdb_ROB = 4'd1; rd_tag_j = 4'd1; rd_tag_k = 4'd3;
    @(posedge clk); #1;
    reset = 1'b0;
    q.delete(); sb.delete(); next_tag = 1;
    @(negedge clk);
    chk("rst_issue_ROB", {28'd0, issue_ROB}, 32'd1);
    chk("rst_issue_ready", {31'd0, issue_ready}, 32'd1);
    chk("rst_rd", {rd_value_j[14:0], rd_value_k[14:0], rd_ready_j, rd_ready_k}, 32'd0);
    chk("rst_commit", {commit_value[25:0], commit_valid, RegWrite, mem_write, flush, commit_ROB[1:0]}, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // In-order retirement despite out-of-order completion.
    step(1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 6, 1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 7, 1, 0, 0, 0, 0, 0, 1, 2);
    step(0, 0, 0, 0, 1, 2, 32'hAA, 0, 2, 1);
    step(0, 0, 0, 0, 1, 1, 32'h11, 0, 1, 2);
    idle(3);

    // Full buffer, commit while full, wrap-around allocation, CDB forwarding.
    do_reset();
    for (int i = 1; i <= 15; i++) step(1, 5'(i), 1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 9, 1, 0, 1, 1, 32'h1234, 0, 1, 0);
    step(1, 9, 1, 0, 1, 4, 32'hCAFE, 0, 4, 5);
    step(1, 10, 1, 0, 0, 0, 0, 0, 4, 1);
    idle(2);

    // Mispredicted branch with younger entries behind it.
    do_reset();
    for (int i = 1; i <= 8; i++) step(1, 5'(i + 8), 1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 3, 32'h300, 1, 3, 0);
    step(0, 0, 0, 0, 1, 5, 32'h500, 0, 0, 0);
    step(0, 0, 0, 0, 1, 1, 32'h100, 0, 0, 0);
    step(1, 20, 1, 0, 1, 2, 32'h200, 0, 0, 0);
    step(1, 21, 1, 0, 1, 6, 32'h600, 0, 6, 0);
    step(1, 22, 1, 0, 1, 7, 32'h700, 0, 0, 7);
    idle(2);

    // Store to x0, then reset with entries live.
    do_reset();
    step(1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 1, 32'h55, 0, 0, 0);
    idle(2);
    for (int i = 0; i < 6; i++) step(1, 5'(i + 1), 1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 1, 32'h77, 0, 0, 0);
    do_reset();

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      bit w, cm;
      int ct, tj, tk;
      if ($urandom_range(0, 499) == 0) do_reset();
      w  = ($urandom_range(0, 3) != 0);
      cm = ($urandom_range(0, 39) == 0);
      if (q.size() > 0 && $urandom_range(0, 7) != 0) ct = q[$urandom_range(0, q.size() - 1)].tag;
      else ct = $urandom_range(0, 15);
      if (q.size() > 0 && $urandom_range(0, 3) != 0) tj = q[$urandom_range(0, q.size() - 1)].tag;
      else tj = $urandom_range(0, 15);
      tk = ($urandom_range(0, 1) != 0) ? ct : $urandom_range(0, 15);
      step($urandom_range(0, 9) < 6, 5'($urandom_range(0, 31)), w, !w && $urandom_range(0, 1) != 0,
           $urandom_range(0, 9) < 5, ct, $urandom, cm, tj, tk);
    end
    idle(4);
    chk("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
